// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - operand/result handshake bundle for bin2bcd_seq
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  busy;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, busy
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, busy
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble binary to BCD converter, one bit per clock
// Optional leading-zero blanking (4'hF digits) when BIN2BCD_BLANK_LEADING_ZERO_EN is defined.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  bin2bcd_seq_if.slave     bus
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   sreg, sreg_nxt;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   bcd_res;
  logic [BW-1:0]   bcd_fmt;
  logic [BW-1:0]   bcd_q;
  logic            in_ready_c, out_valid_c, busy_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy_c = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction happens on the pre-shift digits; the top carry bit is
  // discarded since DIGITS is sized to hold the largest WIDTH-bit value.
  always_comb begin
    adj = sreg[SW-1 -: BW];
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    sreg_nxt = {adj[BW-2:0], sreg[WIDTH-1:0], 1'b0};
    bcd_res  = sreg_nxt[SW-1 -: BW];
  end

`ifdef BIN2BCD_BLANK_LEADING_ZERO_EN
  always_comb begin
    logic lead;
    lead    = 1'b1;
    bcd_fmt = bcd_res;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (bcd_res[4*i +: 4] != 4'd0) lead = 1'b0;
      if (lead) bcd_fmt[4*i +: 4] = 4'hF;
    end
  end
`else
  assign bcd_fmt = bcd_res;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg  <= '0;
      cnt   <= '0;
      bcd_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sreg <= {{BW{1'b0}}, bus.bin_in};
            cnt  <= '0;
          end
        end
        SHIFT: begin
          sreg <= sreg_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) bcd_q <= bcd_fmt;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.bcd_out   = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq (table + random vs decimal model)
module tb_bin2bcd_seq;
  localparam int W = 16;
  localparam int D = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();
  bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [W-1:0]   bin;
    logic [4*D-1:0] exp;
    int             hold;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal digits by division, then optional blanking above the top non-zero digit.
  function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned    x;
    int             msd;
    r = '0;
    x = v;
    msd = 0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      if (x % 10 != 0) msd = i;
      x = x / 10;
    end
`ifdef BIN2BCD_BLANK_LEADING_ZERO_EN
    for (int i = 1; i < D; i++) if (i > msd) r[4*i +: 4] = 4'hF;
`endif
    return r;
  endfunction

  // Called #1 after a clock edge with the DUT idle; returns #1 after the output handshake edge.
  task automatic convert(input logic [W-1:0] v, input logic [4*D-1:0] exp, input int hold,
                         input string tag);
    int n, busy_n, rdy_n;
    bus.in_valid = 1'b1;
    bus.bin_in   = v;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0; busy_n = 0; rdy_n = 0;
    while (!bus.out_valid && n < 40) begin
      if (bus.busy) busy_n++;
      if (bus.in_ready) rdy_n++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, 16);
    if (n >= 40) return;
    chk({tag, " busy cycles"}, busy_n, 16);
    chk({tag, " in_ready while busy"}, rdy_n, 0);
    chk({tag, " bcd_out"}, bus.bcd_out, exp);
    chk({tag, " busy in done"}, bus.busy, 0);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.bin_in   = 16'd42;
      @(posedge clk); #1;
      chk({tag, " hold out_valid"}, bus.out_valid, 1);
      chk({tag, " hold bcd_out"}, bus.bcd_out, exp);
      chk({tag, " hold in_ready"}, bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, " out_valid after hs"}, bus.out_valid, 0);
    chk({tag, " in_ready after hs"}, bus.in_ready, 1);
    chk({tag, " bcd held after hs"}, bus.bcd_out, exp);
  endtask

  initial begin
`ifdef BIN2BCD_BLANK_LEADING_ZERO_EN
    vecs[0] = '{16'd0,     20'hFFFF0, 0};
    vecs[1] = '{16'd255,   20'hFF255, 0};
    vecs[2] = '{16'd65535, 20'h65535, 1};
    vecs[3] = '{16'd9999,  20'hF9999, 0};
    vecs[4] = '{16'd10000, 20'h10000, 2};
    vecs[5] = '{16'd1234,  20'hF1234, 10};
    vecs[6] = '{16'd7,     20'hFFFF7, 0};
    vecs[7] = '{16'd305,   20'hFF305, 3};
`else
    vecs[0] = '{16'd0,     20'h00000, 0};
    vecs[1] = '{16'd255,   20'h00255, 0};
    vecs[2] = '{16'd65535, 20'h65535, 1};
    vecs[3] = '{16'd9999,  20'h09999, 0};
    vecs[4] = '{16'd10000, 20'h10000, 2};
    vecs[5] = '{16'd1234,  20'h01234, 10};
    vecs[6] = '{16'd7,     20'h00007, 0};
    vecs[7] = '{16'd305,   20'h00305, 3};
`endif
    bus.in_valid  = 1'b0;
    bus.bin_in    = '0;
    bus.out_ready = 1'b0;

    #12;
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset bcd_out", bus.bcd_out, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("idle out_ready in_ready", bus.in_ready, 1);
    chk("idle out_ready out_valid", bus.out_valid, 0);

    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].bin, vecs[i].exp, vecs[i].hold, $sformatf("vec%0d", i));
    end

    // Abort mid-conversion with an asynchronous reset between clock edges.
    bus.in_valid = 1'b1;
    bus.bin_in   = 16'd4321;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", bus.out_valid, 0);
    chk("midrst bcd_out", bus.bcd_out, 0);
    chk("midrst in_ready", bus.in_ready, 1);
    chk("midrst busy", bus.busy, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after rst in_ready", bus.in_ready, 1);
    chk("after rst out_valid", bus.out_valid, 0);
    convert(16'd7, ref_bcd(7), 0, "post-reset 7");

    for (int r = 0; r < 30; r++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      if (r == 0) v = 16'hFFFF;
      if (r == 1) v = 16'd0;
      convert(v, ref_bcd(v), int'($urandom_range(0, 3)), $sformatf("rand%0d(%0d)", r, v));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
